// File: rtl/if_trace_unit.sv
// rtl/if_trace_unit.sv - instruction-fetch trace unit pairing grants with responses and queueing filtered records
//
// Purpose: tracks outstanding fetch grants in an address FIFO, pairs each fetch
// response with the oldest granted address, filters by instruction class and
// queues {instr, addr, time} records in an output FIFO drained by a
// valid/ready handshake. Protocol violations latch a sticky error state.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   counter                   free-running timestamp
//   instr_gnt, instr_addr     fetch grant and its address
//   instr_rvalid, instr_rdata fetch response and instruction word
//   trace_en, filter_mode     recording enable, class filter select
//   trace_valid, trace_ready  record handshake
//   trace_instr/addr/time     record payload (head of output FIFO, zero when empty)
//   drop_count                saturating count of records lost to a full output FIFO
//   proto_err                 sticky protocol-error flag
module if_trace_unit #(
    parameter int INSTR_ADDR_WIDTH = 16,
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int COUNTER_WIDTH    = 32,
    parameter int ADDR_DEPTH       = 4,
    parameter int OUT_DEPTH        = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [COUNTER_WIDTH-1:0]    counter,
    input  logic                        instr_gnt,
    input  logic [INSTR_ADDR_WIDTH-1:0] instr_addr,
    input  logic                        instr_rvalid,
    input  logic [INSTR_DATA_WIDTH-1:0] instr_rdata,
    input  logic                        trace_en,
    input  logic [1:0]                  filter_mode,
    output logic                        trace_valid,
    input  logic                        trace_ready,
    output logic [INSTR_DATA_WIDTH-1:0] trace_instr,
    output logic [INSTR_ADDR_WIDTH-1:0] trace_addr,
    output logic [COUNTER_WIDTH-1:0]    trace_time,
    output logic [15:0]                 drop_count,
    output logic                        proto_err
);

    localparam int AP = $clog2(ADDR_DEPTH);
    localparam int OP = $clog2(OUT_DEPTH);
    localparam int RW = INSTR_DATA_WIDTH + INSTR_ADDR_WIDTH + COUNTER_WIDTH;

    typedef enum logic {RUN, ERROR} state_t;
    state_t state, state_next;

    // Address FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [INSTR_ADDR_WIDTH-1:0] addr_mem [ADDR_DEPTH];
    logic [AP:0] a_wr, a_rd;
    logic        a_empty, a_full, a_push, a_pop;
    logic [INSTR_ADDR_WIDTH-1:0] a_head;

    assign a_empty = (a_wr == a_rd);
    assign a_full  = (a_wr[AP] != a_rd[AP]) && (a_wr[AP-1:0] == a_rd[AP-1:0]);
    assign a_head  = addr_mem[a_rd[AP-1:0]];
    assign a_pop   = instr_rvalid && !a_empty;
    // A full FIFO still takes a grant when the head leaves in the same cycle.
    assign a_push  = instr_gnt && (!a_full || a_pop);

    always_ff @(posedge clk) begin
        if (a_push) begin
            addr_mem[a_wr[AP-1:0]] <= instr_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_wr <= '0;
            a_rd <= '0;
        end else begin
            if (a_push) a_wr <= a_wr + 1'b1;
            if (a_pop)  a_rd <= a_rd + 1'b1;
        end
    end

    // Instruction classification on the RISC-V major opcode.
    logic [6:0] opcode;
    logic       is_ls, is_cf, match;

    assign opcode = instr_rdata[6:0];
    assign is_ls  = (opcode == 7'b0000011) || (opcode == 7'b0100011);
    assign is_cf  = (opcode == 7'b1100011) || (opcode == 7'b1101111) ||
                    (opcode == 7'b1100111);

    always_comb begin
        match = 1'b0;
        case (filter_mode)
            2'd0:    match = is_ls;
            2'd1:    match = is_cf;
            2'd2:    match = 1'b1;
            default: match = is_ls || is_cf;
        endcase
    end

    // Output record FIFO.
    logic [RW-1:0] out_mem [OUT_DEPTH];
    logic [OP:0]   o_wr, o_rd;
    logic          o_empty, o_full, o_pop, o_push, rec_want, rec_drop;
    logic [RW-1:0] o_head;

    assign o_empty  = (o_wr == o_rd);
    assign o_full   = (o_wr[OP] != o_rd[OP]) && (o_wr[OP-1:0] == o_rd[OP-1:0]);
    assign o_pop    = trace_valid && trace_ready;
    assign rec_want = a_pop && trace_en && match && (state == RUN);
    assign o_push   = rec_want && (!o_full || o_pop);
    assign rec_drop = rec_want && o_full && !o_pop;

    always_ff @(posedge clk) begin
        if (o_push) begin
            out_mem[o_wr[OP-1:0]] <= {instr_rdata, a_head, counter};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_wr       <= '0;
            o_rd       <= '0;
            drop_count <= '0;
        end else begin
            if (o_push) o_wr <= o_wr + 1'b1;
            if (o_pop)  o_rd <= o_rd + 1'b1;
            if (rec_drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Payload reads as zero while empty so stale storage never leaks out.
    assign o_head      = o_empty ? '0 : out_mem[o_rd[OP-1:0]];
    assign trace_valid = !o_empty;
    assign trace_instr = o_head[RW-1 -: INSTR_DATA_WIDTH];
    assign trace_addr  = o_head[COUNTER_WIDTH +: INSTR_ADDR_WIDTH];
    assign trace_time  = o_head[COUNTER_WIDTH-1:0];

    // Protocol FSM: a response with nothing outstanding (a same-cycle grant
    // gives no credit) or a grant overflowing the address FIFO is fatal.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        proto_err  = (state == ERROR);
        if (state == RUN) begin
            if ((instr_rvalid && a_empty) || (instr_gnt && a_full && !a_pop)) begin
                state_next = ERROR;
            end
        end
    end

endmodule

// File: tb/tb_if_trace_unit.sv
// tb/tb_if_trace_unit.sv - directed self-checking bench for if_trace_unit
module tb_if_trace_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] counter;
    logic        instr_gnt;
    logic [15:0] instr_addr;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        trace_en;
    logic [1:0]  filter_mode;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_instr;
    logic [15:0] trace_addr;
    logic [31:0] trace_time;
    logic [15:0] drop_count;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_trace_unit dut (
        .clk          (clk),
        .rst          (rst),
        .counter      (counter),
        .instr_gnt    (instr_gnt),
        .instr_addr   (instr_addr),
        .instr_rvalid (instr_rvalid),
        .instr_rdata  (instr_rdata),
        .trace_en     (trace_en),
        .filter_mode  (filter_mode),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_instr  (trace_instr),
        .trace_addr   (trace_addr),
        .trace_time   (trace_time),
        .drop_count   (drop_count),
        .proto_err    (proto_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        instr_gnt    = 1'b0;
        instr_rvalid = 1'b0;
    endtask

    task automatic grant(input logic [15:0] a);
        instr_gnt  = 1'b1;
        instr_addr = a;
    endtask

    task automatic resp(input logic [31:0] d, input logic [31:0] t);
        instr_rvalid = 1'b1;
        instr_rdata  = d;
        counter      = t;
    endtask

    initial begin
        rst = 1'b1; counter = '0; instr_addr = '0; instr_rdata = '0;
        trace_en = 1'b1; filter_mode = 2'd0; trace_ready = 1'b1;
        idle();
        step();
        rst = 1'b0;
        chk("rst_valid", trace_valid, 0);
        chk("rst_instr", trace_instr, 0);
        chk("rst_addr",  trace_addr, 0);
        chk("rst_time",  trace_time, 0);
        chk("rst_drop",  drop_count, 0);
        chk("rst_err",   proto_err, 0);

        // Single load
        grant(16'h0100); step(); idle();
        resp(32'h00012083, 32'd50); step(); idle();
        chk("single_valid", trace_valid, 1);
        chk("single_instr", trace_instr, 32'h00012083);
        chk("single_addr",  trace_addr, 16'h0100);
        chk("single_time",  trace_time, 50);
        step();
        chk("single_popped", trace_valid, 0);

        // Pipelined grants then responses, held under backpressure
        trace_ready = 1'b0;
        grant(16'h0010); step();
        grant(16'h0014); step();
        grant(16'h0018); step(); idle();
        resp(32'h00002003, 32'd100); step();
        resp(32'h00002003, 32'd101); step();
        resp(32'h00002003, 32'd102); step(); idle();
        chk("pipe_addr0", trace_addr, 16'h0010);
        step();
        chk("pipe_hold_addr", trace_addr, 16'h0010);
        chk("pipe_hold_time", trace_time, 100);
        trace_ready = 1'b1;
        step();
        chk("pipe_addr1", trace_addr, 16'h0014);
        chk("pipe_time1", trace_time, 101);
        step();
        chk("pipe_addr2", trace_addr, 16'h0018);
        step();
        chk("pipe_empty", trace_valid, 0);

        // Filter: control-flow only
        trace_ready = 1'b0; filter_mode = 2'd1;
        grant(16'h0020); step();
        grant(16'h0024); step(); idle();
        resp(32'h0000006F, 32'd200); step();
        resp(32'h00002003, 32'd201); step(); idle();
        chk("cf_instr", trace_instr, 32'h0000006F);
        chk("cf_addr",  trace_addr, 16'h0020);
        trace_ready = 1'b1; step();
        chk("cf_only_one", trace_valid, 0);

        // Filter: all, with grant and response coinciding
        trace_ready = 1'b0; filter_mode = 2'd2;
        grant(16'h0030); step();
        grant(16'h0034); resp(32'h0000006F, 32'd300); step(); idle();
        resp(32'h00002003, 32'd301); step(); idle();
        chk("all_instr0", trace_instr, 32'h0000006F);
        chk("all_addr0",  trace_addr, 16'h0030);
        trace_ready = 1'b1; step();
        chk("all_instr1", trace_instr, 32'h00002003);
        chk("all_addr1",  trace_addr, 16'h0034);
        chk("all_time1",  trace_time, 301);
        step();
        chk("all_empty", trace_valid, 0);

        // Backpressure: five loads into a four-deep record FIFO
        trace_ready = 1'b0; filter_mode = 2'd0;
        grant(16'h0040); step();
        grant(16'h0044); resp(32'h00002003, 32'd400); step();
        grant(16'h0048); resp(32'h00002003, 32'd401); step();
        grant(16'h004C); resp(32'h00002003, 32'd402); step();
        grant(16'h0050); resp(32'h00002003, 32'd403); step(); idle();
        resp(32'h00002003, 32'd404); step(); idle();
        chk("bp_drop",  drop_count, 1);
        chk("bp_valid", trace_valid, 1);
        chk("bp_addr0", trace_addr, 16'h0040);
        trace_ready = 1'b1; step();
        chk("bp_addr1", trace_addr, 16'h0044);
        step();
        chk("bp_addr2", trace_addr, 16'h0048);
        step();
        chk("bp_addr3", trace_addr, 16'h004C);
        chk("bp_time3", trace_time, 403);
        step();
        chk("bp_empty", trace_valid, 0);
        chk("bp_no_err", proto_err, 0);

        // Protocol error: response with nothing outstanding
        resp(32'h00002003, 32'd500); step(); idle();
        chk("perr_set", proto_err, 1);
        grant(16'h0070); step(); idle();
        resp(32'h00002003, 32'd501); step(); idle();
        chk("perr_no_record", trace_valid, 0);
        chk("perr_sticky", proto_err, 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("perr_cleared", proto_err, 0);
        chk("perr_drop_clr", drop_count, 0);

        // Reset mid-operation
        trace_ready = 1'b0;
        grant(16'h0080); step();
        grant(16'h0084); step();
        grant(16'h0088); resp(32'h00002003, 32'd600); step();
        grant(16'h008C); resp(32'h00002003, 32'd601); step(); idle();
        chk("mid_queued", trace_valid, 1);
        chk("mid_addr", trace_addr, 16'h0080);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_valid", trace_valid, 0);
        chk("mid_rst_instr", trace_instr, 0);
        step();
        chk("mid_after_valid", trace_valid, 0);
        resp(32'h00002003, 32'd700); step(); idle();
        chk("mid_stale_err", proto_err, 1);
        chk("mid_stale_valid", trace_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_trace_unit.md
IF_TRACE_UNIT -- requirements
Module: if_trace_unit

Interface
REQ-001 SHALL have parameter INSTR_ADDR_WIDTH, default 16, instruction address width.
REQ-002 SHALL have parameter INSTR_DATA_WIDTH, default 32, instruction word width (≥7).
REQ-003 SHALL have parameter COUNTER_WIDTH, default 32, timestamp width.
REQ-004 SHALL have parameter ADDR_DEPTH, default 4, outstanding-grant FIFO depth (power of 2, ≥2).
REQ-005 SHALL have parameter OUT_DEPTH, default 4, trace-record FIFO depth (power of 2, ≥2).
REQ-006 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port counter  in  COUNTER_WIDTH  free-running timestamp.
REQ-009 SHALL have ports instr_gnt (in, 1) and instr_addr (in, INSTR_ADDR_WIDTH): the address is accepted on a grant.
REQ-010 SHALL have ports instr_rvalid (in, 1) and instr_rdata (in, INSTR_DATA_WIDTH): fetch response.
REQ-011 SHALL have port trace_en  in  1  recording enable.
REQ-012 SHALL have port filter_mode  in  2  0=load/store, 1=control-flow, 2=all, 3=load/store+control-flow.
REQ-013 SHALL have ports trace_valid (out, 1) and trace_ready (in, 1): record handshake.
REQ-014 SHALL have ports trace_instr (out, INSTR_DATA_WIDTH), trace_addr (out, INSTR_ADDR_WIDTH) and trace_time (out, COUNTER_WIDTH): record payload.
REQ-015 SHALL have port drop_count  out  16  records lost to a full output FIFO.
REQ-016 SHALL have port proto_err  out  1  sticky protocol-error flag.

Function
REQ-017 SHALL push instr_addr into the address FIFO on every cycle with instr_gnt=1, regardless of trace_en.
REQ-018 SHALL pop the address FIFO head on every instr_rvalid=1 and pair it with instr_rdata.
REQ-019 SHALL, when instr_gnt and instr_rvalid coincide, pop and push in the same cycle; the response pairs with the pre-existing head.
REQ-020 SHALL classify a word as load/store when bits[6:0] = 0000011 or 0100011.
REQ-021 SHALL classify a word as control-flow when bits[6:0] = 1100011, 1101111 or 1100111.
REQ-022 SHALL sample filter_mode and trace_en in the rvalid cycle.
REQ-023 SHALL write {rdata, paired addr, counter in the rvalid cycle} into the output FIFO when trace_en=1, the filter matches and state is RUN.
REQ-024 SHALL present the output FIFO head combinationally on the payload ports, with trace_valid = not empty; the record is visible the cycle after rvalid (latency 1).
REQ-025 SHALL hold payload stable while trace_valid=1 and trace_ready=0, and pop the record on trace_valid&&trace_ready.
REQ-026 SHALL accept a write into a full output FIFO if a pop occurs in the same cycle.
REQ-027 SHALL otherwise discard a matching record when the output FIFO is full and increment drop_count, saturating at 16'hFFFF.
REQ-028 SHALL implement states RUN and ERROR; reset enters RUN.
REQ-029 SHALL transition RUN→ERROR on instr_rvalid with an empty address FIFO (no simultaneous gnt credit).
REQ-030 SHALL transition RUN→ERROR on instr_gnt with a full address FIFO and no simultaneous pop; the grant is discarded.
REQ-031 SHALL, in ERROR, assert proto_err, stop writing records, still drain the output FIFO via the handshake, and leave ERROR only on rst.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, empty both FIFOs and set trace_valid=0, drop_count=0, proto_err=0, state=RUN, trace_instr/trace_addr/trace_time=0.
REQ-033 SHALL discard all in-flight grants and records on reset mid-operation, with no output in the cycle after reset.

Verification
REQ-034 SHALL verify a single load: gnt addr 0x0100, rvalid rdata 0x00012083 at counter=50, trace_ready=1 → trace_valid the next cycle with instr 0x00012083, addr 0x0100, time 50.
REQ-035 SHALL verify pipelining: three grants 0x10/0x14/0x18, then three rvalids with loads → three records in order with addrs 0x10, 0x14, 0x18.
REQ-036 SHALL verify the filter: mode 1, rdata 0x0000006F (jal) then 0x00002003 (lw) → only the jal is recorded; mode 2 → both are recorded.
REQ-037 SHALL verify backpressure: trace_ready=0, five matching loads with OUT_DEPTH=4 → four records are held and drop_count=1; then trace_ready=1 → four records drain in order.
REQ-038 SHALL verify a protocol error: rvalid with no prior grant → proto_err=1 next cycle, later matches are not recorded, and rst clears it to 0.
REQ-039 SHALL verify reset mid-operation: two grants outstanding plus two queued records, then rst → trace_valid=0, and later rvalids without grants raise proto_err.
